mod_reducer: RTL and testbench

//  Conditional modular subtraction stage directly downstream of the 514-bit adder.

---
 rtl/mod_reducer_pkg.sv | 19 +
 rtl/mod_reducer_limb_sub.sv | 19 +
 rtl/mod_reducer.sv | 118 +++++++++++
 tb/tb_mod_reducer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_reducer_pkg.sv
// Shared constants and state encoding for the limb-serial conditional modular reducer.
// Build option: define MODRED_EARLY_EXIT_EN to enable the top-limb early-exit path.
package mod_reducer_pkg;

  localparam int unsigned N        = 514;
  localparam int unsigned Limb     = 128;
  localparam int unsigned NumLimbs = (N + 1 + Limb - 1) / Limb;
  localparam int unsigned ExtW     = NumLimbs * Limb;
  localparam int unsigned IdxW     = $clog2(NumLimbs);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLimbs - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StSel  = 2'd2
  } state_e;

endpackage

// File: rtl/mod_reducer_limb_sub.sv
// One limb of the subtract chain: {bout, diff} = a - b - bin. Purely combinational.
module mod_reducer_limb_sub
  import mod_reducer_pkg::*;
(
  input  logic [Limb-1:0] a_i,
  input  logic [Limb-1:0] b_i,
  input  logic            bin_i,
  output logic [Limb-1:0] diff_o,
  output logic            bout_o
);

  logic [Limb:0] full;

  // The extra top bit goes to one exactly when a - b - bin is negative.
  assign full   = {1'b0, a_i} - {1'b0, b_i} - {{Limb{1'b0}}, bin_i};
  assign diff_o = full[Limb-1:0];
  assign bout_o = full[Limb];

endmodule

// File: rtl/mod_reducer.sv
// Conditional modular subtraction s mod M (s < 2M), one limb per cycle via a shared subtractor.
// Build option: MODRED_EARLY_EXIT_EN skips the subtract pass when top(s) < top(M).
module mod_reducer
  import mod_reducer_pkg::*;
(
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         start_i,
  input  logic [N:0]   in_sum_i,
  input  logic [N-1:0] in_mod_i,
  output logic [N-1:0] result_o,
  output logic         done_o,
  output logic         busy_o
);

  state_e              state_q, state_d;
  logic [ExtW-1:0]     s_q, s_d;
  logic [ExtW-1:0]     m_q, m_d;
  logic [ExtW-1:0]     diff_q, diff_d;
  logic                borrow_q, borrow_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [N-1:0]        result_q, result_d;
  logic                done_q, done_d;

  logic [ExtW-1:0]     s_ext, m_ext;
  logic [Limb-1:0]     limb_diff;
  logic                limb_bout;
  logic                early_exit;

  assign s_ext = {{(ExtW - N - 1){1'b0}}, in_sum_i};
  assign m_ext = {{(ExtW - N){1'b0}}, in_mod_i};

`ifdef MODRED_EARLY_EXIT_EN
  // Strictly smaller top limb already proves s < M, so s is the answer.
  assign early_exit = (s_ext[ExtW-1 -: Limb] < m_ext[ExtW-1 -: Limb]);
`else
  assign early_exit = 1'b0;
`endif

  mod_reducer_limb_sub u_limb_sub (
    .a_i    (s_q[Limb-1:0]),
    .b_i    (m_q[Limb-1:0]),
    .bin_i  (borrow_q),
    .diff_o (limb_diff),
    .bout_o (limb_bout)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    m_d      = m_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          s_d      = s_ext;
          m_d      = m_ext;
          diff_d   = '0;
          idx_d    = '0;
          borrow_d = early_exit;
          state_d  = early_exit ? StSel : StSub;
        end
      end
      StSub: begin
        // s rotates so it is back in place for the final select; d fills from the top.
        s_d      = {s_q[Limb-1:0], s_q[ExtW-1:Limb]};
        m_d      = {{Limb{1'b0}}, m_q[ExtW-1:Limb]};
        diff_d   = {limb_diff, diff_q[ExtW-1:Limb]};
        borrow_d = limb_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StSel;
        end
      end
      StSel: begin
        result_d = borrow_q ? s_q[N-1:0] : diff_q[N-1:0];
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= StIdle;
      s_q      <= '0;
      m_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      m_q      <= m_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;
  // Busy covers the done cycle too, even though the FSM is already back in idle.
  assign busy_o   = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_mod_reducer.sv
// Self-checking bench for mod_reducer: vector table, random ops against an arithmetic model,
// and hand-written sequences for ignored starts, async reset and back-to-back operation.
module tb_mod_reducer;

  localparam int N    = 514;
  localparam int LIMB = 128;
  localparam int NL   = 5;
  localparam int TOPB = (NL - 1) * LIMB;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [N:0]   in_sum;
  logic [N-1:0] in_mod;
  logic [N-1:0] result;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mod_reducer dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .start_i  (start),
    .in_sum_i (in_sum),
    .in_mod_i (in_mod),
    .result_o (result),
    .done_o   (done),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N:0]   s;
    logic [N-1:0] m;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: s mod M for s < 2M; otherwise s - M truncated to N bits.
  function automatic logic [N-1:0] ref_mod(input logic [N:0] s, input logic [N-1:0] m);
    logic [N:0] me;
    logic [N:0] d;
    me = {1'b0, m};
    d  = s - me;
    if (s >= me) return d[N-1:0];
    return s[N-1:0];
  endfunction

  // Edge of done, counting the edge that accepts start as edge 1.
  function automatic int exp_lat(input logic [N:0] s, input logic [N-1:0] m);
`ifdef MODRED_EARLY_EXIT_EN
    logic [N:0] me;
    me = {1'b0, m};
    if ((s >> TOPB) < (me >> TOPB)) return 2;
`endif
    return NL + 2;
  endfunction

  function automatic logic [N:0] rand_wide();
    logic [543:0] tmp;
    tmp = '0;
    for (int i = 0; i < 17; i++) tmp = {tmp[511:0], 32'($urandom())};
    return tmp[N:0];
  endfunction

  // Called at posedge+1 with the DUT idle; returns in the done cycle.
  task automatic run_op(input logic [N:0] s, input logic [N-1:0] m,
                        output logic [N-1:0] res, output int lat, output bit busy_ok);
    start  = 1'b1;
    in_sum = s;
    in_mod = m;
    @(posedge clk); #1;
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    res     = '0;
    for (int e = 1; e <= 40; e++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = e;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic full_op(input string nm, input logic [N:0] s, input logic [N-1:0] m,
                         input logic [N-1:0] exp);
    logic [N-1:0] res;
    int lat;
    bit busy_ok;
    run_op(s, m, res, lat, busy_ok);
    check({nm, " result"}, {1'b0, res}, {1'b0, exp});
    check({nm, " done_edge"}, (N+1)'(lat), (N+1)'(exp_lat(s, m)));
    check({nm, " busy_span"}, (N+1)'(busy_ok), (N+1)'(1));
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, (N+1)'(done), (N+1)'(0));
  endtask

  initial begin
    logic [N:0]   s;
    logic [N-1:0] m;
    logic [N-1:0] res;
    logic [N+1:0] big;
    logic [N+1:0] two_m;
    logic [N:0]   one;
    int           dones;
    int           done_edges[$];

    one = 1;
    vecs[0] = '{s: 515'd5, m: 514'd7, exp: 514'd5};
    vecs[1] = '{s: 515'd7, m: 514'd7, exp: 514'd0};
    vecs[2] = '{s: 515'h1_0000, m: 514'hFFFF, exp: 514'd1};
    vecs[3].s   = one << 514;
    vecs[3].m   = N'(one << 513) + 514'd1;
    vecs[3].exp = N'(one << 513) - 514'd1;
    vecs[4] = '{s: 515'd0, m: 514'd7, exp: 514'd0};
    vecs[5] = '{s: 515'd9, m: 514'd4, exp: 514'd5};
    vecs[6].s   = (one << 200) + 515'd3;
    vecs[6].m   = N'(one << 200);
    vecs[6].exp = 514'd3;
    vecs[7].s   = (one << 300) - 515'd1;
    vecs[7].m   = N'(one << 299) + 514'd10;
    vecs[7].exp = N'(one << 299) - 514'd11;

    resetn = 1'b0;
    start  = 1'b0;
    in_sum = '0;
    in_mod = '0;
    #12;
    check("reset result", {1'b0, result}, '0);
    check("reset done", (N+1)'(done), '0);
    check("reset busy", (N+1)'(busy), '0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      full_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].m, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      s = rand_wide();
      m = s[N-1:0];
      m = m >> $urandom_range(0, 500);
      if (m == '0) m = 1;
      big   = {1'b0, rand_wide()};
      two_m = {1'b0, m, 1'b0};
      big   = big % two_m;
      s     = big[N:0];
      if (i % 8 == 0) s = {1'b0, m};
      if (i % 8 == 1) s = two_m[N:0] - 1'b1;
      full_op($sformatf("rand%0d", i), s, m, ref_mod(s, m));
    end

    // Starts at edges 3 and 5 of an op are ignored.
    start = 1'b1; in_sum = 515'd20; in_mod = 514'd13;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    res   = '0;
    for (int e = 2; e <= 15; e++) begin
      start  = (e == 3 || e == 5);
      in_sum = start ? 515'h55 : 515'd20;
      in_mod = start ? 514'd3 : 514'd13;
      @(posedge clk); #1;
      if (done) begin
        dones++;
        res = result;
      end
    end
    start = 1'b0;
    check("ignored_start done_count", (N+1)'(dones), (N+1)'(1));
    check("ignored_start result", {1'b0, res}, 515'd7);

    // Async reset mid-operation.
    full_op("pre_reset", 515'd5, 514'd7, 514'd5);
    start = 1'b1; in_sum = 515'd100; in_mod = 514'd60;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("midreset result", {1'b0, result}, '0);
    check("midreset done", (N+1)'(done), '0);
    check("midreset busy", (N+1)'(busy), '0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("midreset no_done", (N+1)'(dones), '0);
    full_op("post_reset", 515'd100, 514'd60, 514'd40);

    // Start held high: back-to-back acceptance, precondition violated (9 >= 2*4).
    start = 1'b1; in_sum = 515'd9; in_mod = 514'd4;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (e == 20) start = 1'b0;
      if (done) begin
        done_edges.push_back(e);
        check($sformatf("b2b result@%0d", e), {1'b0, result}, 515'd5);
      end
    end
    check("b2b done_count", (N+1)'(done_edges.size()), (N+1)'(3));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b done_edge%0d", k),
            (N+1)'((k < done_edges.size()) ? done_edges[k] : -1), (N+1)'(7 * (k + 1)));
    end

`ifdef MODRED_EARLY_EXIT_EN
    full_op("early_exit", 515'd3, N'(one << 513), 514'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
